// File: rtl/c2f_req_fifo.sv
// c2f_req_fifo
//   Core-to-fabric request queue. Core-side requests are pushed into a DEPTH
//   entry circular buffer and presented in order to the ring. The block also
//   tracks, per thread, whether a read is outstanding in the fabric. It flags
//   lost pushes and a second read issued while one is already outstanding.
//
// Ports
//   QClk                  core clock, all state on rising edge
//   RstQnnnH              synchronous active-high reset
//   C2F_ReqValidQ500H     push request
//   C2F_ReqOpcodeQ500H    opcode, 1'b0 = RD, 1'b1 = WR
//   C2F_ReqThreadIDQ500H  issuing thread
//   C2F_ReqAddressQ500H   target address
//   C2F_ReqDataQ500H      write data
//   C2F_RspValidQ502H     fabric read response valid
//   C2F_RspThreadIDQ502H  thread of the response
//   RingReqReadyQ501H     ring slot free, head may pop
//   RingReqValidQ501H     head entry valid
//   RingReqOpcodeQ501H / ThreadIDQ501H / AddressQ501H / DataQ501H
//                         head entry fields, zero when empty
//   C2F_RspStall          FIFO full
//   RdPendingQnnnH        per-thread outstanding-read bits
//   OverflowErr           sticky, a push was dropped while full
//   DoubleRdErr           sticky, a read was accepted while one was pending
module c2f_req_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        QClk,
  input  logic        RstQnnnH,
  input  logic        C2F_ReqValidQ500H,
  input  logic        C2F_ReqOpcodeQ500H,
  input  logic [1:0]  C2F_ReqThreadIDQ500H,
  input  logic [31:0] C2F_ReqAddressQ500H,
  input  logic [31:0] C2F_ReqDataQ500H,
  input  logic        C2F_RspValidQ502H,
  input  logic [1:0]  C2F_RspThreadIDQ502H,
  input  logic        RingReqReadyQ501H,
  output logic        RingReqValidQ501H,
  output logic        RingReqOpcodeQ501H,
  output logic [1:0]  RingReqThreadIDQ501H,
  output logic [31:0] RingReqAddressQ501H,
  output logic [31:0] RingReqDataQ501H,
  output logic        C2F_RspStall,
  output logic [3:0]  RdPendingQnnnH,
  output logic        OverflowErr,
  output logic        DoubleRdErr
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic          OP_RD    = 1'b0;
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef struct packed {
    logic        op;
    logic [1:0]  tid;
    logic [31:0] addr;
    logic [31:0] data;
  } reqEntry_t;

  reqEntry_t       mem [DEPTH];
  reqEntry_t       headEntry, pushEntry;
  logic [PW-1:0]   wrPtr, rdPtr;
  logic [PW:0]     count;
  logic            full, notEmpty, pop, push, rdPush;
  logic [3:0]      pendSet, pendClr;

  always_comb begin
    notEmpty = (count != '0);
    full     = (count == FULL_CNT);
    pop      = notEmpty && RingReqReadyQ501H;
    // A pop frees the slot this cycle, so a full FIFO still accepts the push.
    push     = C2F_ReqValidQ500H && (!full || pop);
    rdPush   = push && (C2F_ReqOpcodeQ500H == OP_RD);

    pendSet = '0;
    if (rdPush) pendSet[C2F_ReqThreadIDQ500H] = 1'b1;
    pendClr = '0;
    if (C2F_RspValidQ502H) pendClr[C2F_RspThreadIDQ502H] = 1'b1;

    pushEntry = '{op:   C2F_ReqOpcodeQ500H,
                  tid:  C2F_ReqThreadIDQ500H,
                  addr: C2F_ReqAddressQ500H,
                  data: C2F_ReqDataQ500H};

    // Head is read from registered storage only, so nothing pushed this cycle
    // can reach the ring before the next one.
    headEntry = notEmpty ? mem[rdPtr] : '0;
  end

  assign RingReqValidQ501H    = notEmpty;
  assign RingReqOpcodeQ501H   = headEntry.op;
  assign RingReqThreadIDQ501H = headEntry.tid;
  assign RingReqAddressQ501H  = headEntry.addr;
  assign RingReqDataQ501H     = headEntry.data;
  assign C2F_RspStall         = full;

  // Storage is not reset; stale entries are unreachable once count is zero.
  always_ff @(posedge QClk) begin
    if (push) mem[wrPtr] <= pushEntry;
  end

  always_ff @(posedge QClk) begin
    if (RstQnnnH) begin
      wrPtr          <= '0;
      rdPtr          <= '0;
      count          <= '0;
      RdPendingQnnnH <= '0;
      OverflowErr    <= 1'b0;
      DoubleRdErr    <= 1'b0;
    end else begin
      // Pointers are log2(DEPTH) bits, so the increment wraps naturally.
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop)  rdPtr <= rdPtr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      // Set is applied after clear so a same-cycle new read keeps the bit.
      RdPendingQnnnH <= (RdPendingQnnnH & ~pendClr) | pendSet;
      if (C2F_ReqValidQ500H && full && !pop) OverflowErr <= 1'b1;
      if (rdPush && RdPendingQnnnH[C2F_ReqThreadIDQ500H]) DoubleRdErr <= 1'b1;
    end
  end

endmodule

// File: tb/tb_c2f_req_fifo.sv
module tb_c2f_req_fifo;
  localparam int DEPTH = 4;
  localparam bit RD = 1'b0;
  localparam bit WR = 1'b1;

  logic        QClk = 1'b0;
  logic        RstQnnnH;
  logic        C2F_ReqValidQ500H;
  logic        C2F_ReqOpcodeQ500H;
  logic [1:0]  C2F_ReqThreadIDQ500H;
  logic [31:0] C2F_ReqAddressQ500H;
  logic [31:0] C2F_ReqDataQ500H;
  logic        C2F_RspValidQ502H;
  logic [1:0]  C2F_RspThreadIDQ502H;
  logic        RingReqReadyQ501H;
  logic        RingReqValidQ501H;
  logic        RingReqOpcodeQ501H;
  logic [1:0]  RingReqThreadIDQ501H;
  logic [31:0] RingReqAddressQ501H;
  logic [31:0] RingReqDataQ501H;
  logic        C2F_RspStall;
  logic [3:0]  RdPendingQnnnH;
  logic        OverflowErr;
  logic        DoubleRdErr;

  always #5 QClk = ~QClk;

  c2f_req_fifo #(.DEPTH(DEPTH)) dut (
    .QClk(QClk), .RstQnnnH(RstQnnnH),
    .C2F_ReqValidQ500H(C2F_ReqValidQ500H), .C2F_ReqOpcodeQ500H(C2F_ReqOpcodeQ500H),
    .C2F_ReqThreadIDQ500H(C2F_ReqThreadIDQ500H), .C2F_ReqAddressQ500H(C2F_ReqAddressQ500H),
    .C2F_ReqDataQ500H(C2F_ReqDataQ500H), .C2F_RspValidQ502H(C2F_RspValidQ502H),
    .C2F_RspThreadIDQ502H(C2F_RspThreadIDQ502H), .RingReqReadyQ501H(RingReqReadyQ501H),
    .RingReqValidQ501H(RingReqValidQ501H), .RingReqOpcodeQ501H(RingReqOpcodeQ501H),
    .RingReqThreadIDQ501H(RingReqThreadIDQ501H), .RingReqAddressQ501H(RingReqAddressQ501H),
    .RingReqDataQ501H(RingReqDataQ501H), .C2F_RspStall(C2F_RspStall),
    .RdPendingQnnnH(RdPendingQnnnH), .OverflowErr(OverflowErr), .DoubleRdErr(DoubleRdErr)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a queue of accepted requests plus per-thread pending bits.
  typedef struct {
    bit        op;
    bit [1:0]  tid;
    bit [31:0] addr;
    bit [31:0] data;
  } ent_t;

  ent_t     q[$];
  bit [3:0] mPend;
  bit       mOvf, mDbl;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit   full, pop, push;
    ent_t e;
    if (RstQnnnH) begin
      q.delete();
      mPend = '0;
      mOvf  = 1'b0;
      mDbl  = 1'b0;
      return;
    end
    full = (q.size() == DEPTH);
    pop  = (q.size() != 0) && RingReqReadyQ501H;
    push = C2F_ReqValidQ500H && (!full || pop);
    if (C2F_ReqValidQ500H && !push) mOvf = 1'b1;
    if (push && C2F_ReqOpcodeQ500H == RD && mPend[C2F_ReqThreadIDQ500H]) mDbl = 1'b1;
    if (C2F_RspValidQ502H) mPend[C2F_RspThreadIDQ502H] = 1'b0;
    if (push && C2F_ReqOpcodeQ500H == RD) mPend[C2F_ReqThreadIDQ500H] = 1'b1;
    if (pop) void'(q.pop_front());
    if (push) begin
      e.op   = C2F_ReqOpcodeQ500H;
      e.tid  = C2F_ReqThreadIDQ500H;
      e.addr = C2F_ReqAddressQ500H;
      e.data = C2F_ReqDataQ500H;
      q.push_back(e);
    end
  endtask

  task automatic checkAll();
    ent_t h;
    h = '{1'b0, 2'b0, 32'h0, 32'h0};
    if (q.size() != 0) h = q[0];
    chk("ring_vld",  RingReqValidQ501H,    64'(q.size() != 0));
    chk("ring_op",   RingReqOpcodeQ501H,   64'(h.op));
    chk("ring_tid",  RingReqThreadIDQ501H, 64'(h.tid));
    chk("ring_addr", RingReqAddressQ501H,  64'(h.addr));
    chk("ring_data", RingReqDataQ501H,     64'(h.data));
    chk("stall",     C2F_RspStall,         64'(q.size() == DEPTH));
    chk("rd_pend",   RdPendingQnnnH,       64'(mPend));
    chk("ovf_err",   OverflowErr,          64'(mOvf));
    chk("dbl_err",   DoubleRdErr,          64'(mDbl));
  endtask

  // One clock: drive, let the edge happen, advance the model, check at negedge.
  task automatic cyc(input bit v, input bit op, input bit [1:0] tid,
                     input bit [31:0] addr, input bit [31:0] data,
                     input bit rv, input bit [1:0] rtid, input bit rdy, input bit rst);
    C2F_ReqValidQ500H    = v;
    C2F_ReqOpcodeQ500H   = op;
    C2F_ReqThreadIDQ500H = tid;
    C2F_ReqAddressQ500H  = addr;
    C2F_ReqDataQ500H     = data;
    C2F_RspValidQ502H    = rv;
    C2F_RspThreadIDQ502H = rtid;
    RingReqReadyQ501H    = rdy;
    RstQnnnH             = rst;
    @(posedge QClk);
    modelStep();
    @(negedge QClk);
    checkAll();
  endtask

  task automatic idle(input bit rdy);
    cyc(1'b0, WR, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, rdy, 1'b0);
  endtask

  task automatic doReset();
    cyc(1'b0, WR, 2'd0, 32'h0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b1);
  endtask

  initial begin
    doReset();
    doReset();
    chk("rst_vld", RingReqValidQ501H, 64'(0));
    chk("rst_stall", C2F_RspStall, 64'(0));

    // Single read, thread 2, then response clears the pending bit.
    cyc(1'b1, RD, 2'd2, 32'h0200_0010, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t043_vld", RingReqValidQ501H, 64'(1));
    chk("t043_addr", RingReqAddressQ501H, 64'h0200_0010);
    chk("t043_pend", RdPendingQnnnH, 64'(4'b0100));
    idle(1'b1);
    chk("t043_popped", RingReqValidQ501H, 64'(0));
    chk("t043_pend_hold", RdPendingQnnnH, 64'(4'b0100));
    cyc(1'b0, WR, 2'd0, 32'h0, 32'h0, 1'b1, 2'd2, 1'b1, 1'b0);
    chk("t043_pend_clr", RdPendingQnnnH, 64'(4'b0000));

    // Five writes with ring stalled: fourth fills, fifth is dropped.
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, WR, 2'(i), 32'h1000 + 32'(i), 32'hD000 + 32'(i), 1'b0, 2'd0, 1'b0, 1'b0);
      if (i == 3) chk("t044_stall", C2F_RspStall, 64'(1));
      if (i == 4) chk("t044_ovf", OverflowErr, 64'(1));
    end
    for (int i = 0; i < 4; i++) begin
      chk("t044_order", RingReqAddressQ501H, 64'(32'h1000 + 32'(i)));
      idle(1'b1);
    end
    chk("t044_drained", RingReqValidQ501H, 64'(0));
    chk("t044_ovf_sticky", OverflowErr, 64'(1));

    // Full FIFO with simultaneous push and pop, across pointer wrap.
    doReset();
    for (int i = 0; i < 4; i++)
      cyc(1'b1, WR, 2'd1, 32'h2000 + 32'(i), 32'(i), 1'b0, 2'd0, 1'b0, 1'b0);
    for (int i = 4; i < 10; i++) begin
      cyc(1'b1, WR, 2'd1, 32'h2000 + 32'(i), 32'(i), 1'b0, 2'd0, 1'b1, 1'b0);
      chk("t045_stall", C2F_RspStall, 64'(1));
      chk("t045_head", RingReqAddressQ501H, 64'(32'h2000 + 32'(i - 3)));
    end
    chk("t045_no_ovf", OverflowErr, 64'(0));
    for (int i = 0; i < 4; i++) begin
      chk("t045_drain", RingReqAddressQ501H, 64'(32'h2000 + 32'(i + 6)));
      idle(1'b1);
    end

    // Double read on thread 0, then response and new read in the same cycle.
    doReset();
    cyc(1'b1, RD, 2'd0, 32'h3000, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("t046_no_dbl", DoubleRdErr, 64'(0));
    cyc(1'b1, RD, 2'd0, 32'h3004, 32'h0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("t046_dbl", DoubleRdErr, 64'(1));
    cyc(1'b1, RD, 2'd0, 32'h3008, 32'h0, 1'b1, 2'd0, 1'b1, 1'b0);
    chk("t046_set_wins", RdPendingQnnnH[0], 64'(1));
    cyc(1'b0, WR, 2'd0, 32'h0, 32'h0, 1'b1, 2'd3, 1'b1, 1'b0);
    chk("t046_stray_rsp", DoubleRdErr, 64'(1));

    // Reset with three entries queued and a push active.
    doReset();
    for (int i = 0; i < 3; i++)
      cyc(1'b1, RD, 2'(i), 32'h4000 + 32'(i), 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    cyc(1'b1, RD, 2'd0, 32'h4003, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t047_dbl_pre", DoubleRdErr, 64'(1));
    cyc(1'b1, WR, 2'd3, 32'h4100, 32'h0, 1'b1, 2'd1, 1'b1, 1'b1);
    chk("t047_vld", RingReqValidQ501H, 64'(0));
    chk("t047_stall", C2F_RspStall, 64'(0));
    chk("t047_pend", RdPendingQnnnH, 64'(0));
    chk("t047_dbl", DoubleRdErr, 64'(0));
    cyc(1'b1, WR, 2'd3, 32'hABCD_0000, 32'h5555_AAAA, 1'b0, 2'd0, 1'b0, 1'b0);
    chk("t047_first_vld", RingReqValidQ501H, 64'(1));
    chk("t047_first_addr", RingReqAddressQ501H, 64'hABCD_0000);

    // Random traffic against the model.
    for (int n = 0; n < 10000; n++) begin
      cyc($urandom_range(0, 9) < 6, 1'($urandom), 2'($urandom), $urandom, $urandom,
          $urandom_range(0, 9) < 3, 2'($urandom), $urandom_range(0, 9) < 5,
          $urandom_range(0, 999) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
